// File: rtl/card_display_pkg.sv
`default_nettype none
// ============================================================================
// card_display_pkg : card codes, segment types and baccarat value helper
// Revision 1.0
// ============================================================================
package card_display_pkg;

  typedef logic [3:0] card_t;
  typedef logic [6:0] seg_t;

  localparam card_t CARD_NONE  = 4'd0;
  localparam card_t CARD_ACE   = 4'd1;
  localparam card_t CARD_TEN   = 4'd10;
  localparam card_t CARD_JACK  = 4'd11;
  localparam card_t CARD_QUEEN = 4'd12;
  localparam card_t CARD_KING  = 4'd13;

  localparam seg_t SEG_BLANK = 7'b1111111;

  // Tens and face cards are worth nothing in baccarat.
  function automatic logic [3:0] card_value(input card_t c);
    return (c >= CARD_ACE && c < CARD_TEN) ? c : 4'd0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/card_display_bank_if.sv
`default_nettype none
// ============================================================================
// card_display_bank_if : dealer-side load/clear bus plus display outputs
// Optional macro SCORE_DIGIT_EN adds the score_hex digit. Revision 1.0
// ============================================================================
interface card_display_bank_if
  import card_display_pkg::*;
#(
  parameter int NUM_SLOTS = 6
);
  localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic                   load;
  logic [SLOT_W-1:0]      slot;
  card_t                  card;
  logic                   clear;
  logic [7*NUM_SLOTS-1:0] hex_out;
  logic [NUM_SLOTS-1:0]   blinking;

`ifdef SCORE_DIGIT_EN
  seg_t                   score_hex;

  modport master (output load, slot, card, clear,
                  input  hex_out, blinking, score_hex);
  modport slave  (input  load, slot, card, clear,
                  output hex_out, blinking, score_hex);
`else
  modport master (output load, slot, card, clear,
                  input  hex_out, blinking);
  modport slave  (input  load, slot, card, clear,
                  output hex_out, blinking);
`endif

endinterface
`default_nettype wire

// File: rtl/card_seg_decode.sv
`default_nettype none
// ============================================================================
// card_seg_decode : card code to active-low 7-segment pattern (bit0 = seg a)
// Revision 1.0
// ============================================================================
module card_seg_decode
  import card_display_pkg::*;
(
  input  card_t card,
  output seg_t  seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (card)
      CARD_ACE:   seg = 7'b0001000;
      4'd2:       seg = 7'b0100100;
      4'd3:       seg = 7'b0110000;
      4'd4:       seg = 7'b0011001;
      4'd5:       seg = 7'b0010010;
      4'd6:       seg = 7'b0000010;
      4'd7:       seg = 7'b1111000;
      4'd8:       seg = 7'b0000000;
      4'd9:       seg = 7'b0010000;
      CARD_TEN:   seg = 7'b1000000;
      CARD_JACK:  seg = 7'b1110001;
      CARD_QUEEN: seg = 7'b0011000;
      CARD_KING:  seg = 7'b0001001;
      default:    seg = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/card_display_bank.sv
`default_nettype none
// ============================================================================
// card_display_bank : NUM_SLOTS card registers driving blinking HEX digits
// Optional macro SCORE_DIGIT_EN adds a hand-score digit. Revision 1.0
// ============================================================================
module card_display_bank
  import card_display_pkg::*;
#(
  parameter int NUM_SLOTS   = 6,
  parameter int BLINK_HALF  = 12_500_000,
  parameter int BLINK_COUNT = 3
)(
  input  wire                 clk,
  input  wire                 reset,
  card_display_bank_if.slave  bus
);

  localparam int SLOT_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int PRE_W    = $clog2(BLINK_HALF);
  localparam int REM_INIT = 2 * BLINK_COUNT;
  localparam int REM_W    = $clog2(REM_INIT + 1);

  logic [PRE_W-1:0] pre;
  logic             tick;
  card_t            load_card;
  card_t            card_reg [NUM_SLOTS];
  logic [REM_W-1:0] rem      [NUM_SLOTS];

  assign tick      = (pre == PRE_W'(BLINK_HALF - 1));
  assign load_card = (bus.card > CARD_KING) ? CARD_NONE : bus.card;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     pre <= '0;
    else if (tick) pre <= '0;
    else           pre <= pre + 1'b1;
  end

  // Out-of-range slot indices match no i, so they leave all state untouched.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        card_reg[i] <= CARD_NONE;
        rem[i]      <= '0;
      end
    end else if (bus.clear) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        card_reg[i] <= CARD_NONE;
        rem[i]      <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (bus.load && bus.slot == SLOT_W'(i)) begin
          card_reg[i] <= load_card;
          rem[i]      <= (load_card != CARD_NONE) ? REM_W'(REM_INIT) : '0;
        end else if (tick && rem[i] != '0) begin
          rem[i] <= rem[i] - REM_W'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    card_t shown;
    seg_t  seg;
    // Odd remaining half-periods are the "off" phase of a blink.
    assign shown = rem[i][0] ? CARD_NONE : card_reg[i];
    card_seg_decode u_dec (.card(shown), .seg(seg));
    assign bus.hex_out[7*i +: 7] = seg;
    assign bus.blinking[i]       = (rem[i] != '0);
  end

`ifdef SCORE_DIGIT_EN
  logic [6:0] score_sum;
  logic [6:0] score_mod;
  card_t      score_digit;

  always_comb begin
    score_sum = '0;
    for (int i = 0; i < NUM_SLOTS; i++)
      score_sum = score_sum + 7'(card_value(card_reg[i]));
  end

  // Digit 0 reuses the "10" pattern, which is the plain zero glyph.
  assign score_mod   = score_sum % 7'd10;
  assign score_digit = (score_mod == 7'd0) ? CARD_TEN : 4'(score_mod);

  card_seg_decode u_score_dec (.card(score_digit), .seg(bus.score_hex));
`endif

endmodule
`default_nettype wire

// File: tb/tb_card_display_bank.sv
`default_nettype none
// ============================================================================
// tb_card_display_bank : randomized bench with a ticks-since-load reference model
// Revision 1.0
// ============================================================================
module tb_card_display_bank;
  import card_display_pkg::*;

  localparam int NS = 6;
  localparam int BH = 4;
  localparam int BC = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  card_display_bank_if #(.NUM_SLOTS(NS)) bus();

  card_display_bank #(
    .NUM_SLOTS  (NS),
    .BLINK_HALF (BH),
    .BLINK_COUNT(BC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model: edges since reset, and per slot the card plus blink ticks seen since its load.
  int k;
  int mcard  [NS];
  int mticks [NS];
  bit mlive  [NS];

  function automatic int norm(input logic [3:0] c);
    return (c > 4'd13) ? 0 : int'(c);
  endfunction

  function automatic logic [6:0] seg_of(input int c);
    case (c)
      1:  return 7'b0001000;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
      10: return 7'b1000000;
      11: return 7'b1110001;
      12: return 7'b0011000;
      13: return 7'b0001001;
      default: return 7'b1111111;
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      k <= 0;
      for (int i = 0; i < NS; i++) begin
        mcard[i]  <= 0;
        mticks[i] <= 0;
        mlive[i]  <= 1'b0;
      end
    end else begin
      k <= k + 1;
      for (int i = 0; i < NS; i++) begin
        if (bus.clear) begin
          mcard[i] <= 0;
          mlive[i] <= 1'b0;
        end else if (bus.load && int'(bus.slot) == i) begin
          mcard[i]  <= norm(bus.card);
          mlive[i]  <= (norm(bus.card) != 0);
          mticks[i] <= 0;
        end else if (k % BH == BH - 1) begin
          mticks[i] <= mticks[i] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic compare_model();
    logic [7*NS-1:0] eh;
    logic [NS-1:0]   eb;
    int r;
    int s;
    if (reset) return;
    s = 0;
    for (int i = 0; i < NS; i++) begin
      r = mlive[i] ? ((2*BC - mticks[i] > 0) ? 2*BC - mticks[i] : 0) : 0;
      eh[7*i +: 7] = (r % 2 == 1) ? 7'b1111111 : seg_of(mcard[i]);
      eb[i] = (r != 0);
      if (mcard[i] < 10) s += mcard[i];
    end
    chk("model_hex_out", bus.hex_out, eh);
    chk("model_blinking", bus.blinking, eb);
`ifdef SCORE_DIGIT_EN
    chk("model_score_hex", bus.score_hex, (s % 10 == 0) ? 7'b1000000 : seg_of(s % 10));
`endif
  endtask

  // Inputs change just after a negedge; outputs are compared at the following negedge.
  task automatic drive(input bit l, input int s, input int c, input bit clr);
    bus.load  = l;
    bus.slot  = 3'(s);
    bus.card  = 4'(c);
    bus.clear = clr;
    @(negedge clk);
    compare_model();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_hex"}, bus.hex_out, {(7*NS){1'b1}});
    chk({tag, "_blink"}, bus.blinking, '0);
`ifdef SCORE_DIGIT_EN
    chk({tag, "_score"}, bus.score_hex, 7'b1000000);
`endif
  endtask

  initial begin
    bus.load  = 1'b0;
    bus.slot  = '0;
    bus.card  = '0;
    bus.clear = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;

    // Idle through prescaler counts 0..2 so the load lands on a tick edge.
    repeat (3) drive(0, 0, 0, 0);
    drive(1, 2, 13, 0);
    for (int n = 1; n <= 17; n++) begin
      if (n > 1) drive(0, 0, 0, 0);
      chk("blink_digit2", bus.hex_out[20:14],
          (n <= 16 && ((n - 1) / 4) % 2 == 1) ? 7'b1111111 : 7'b0001001);
      chk("blink_flag2", bus.blinking[2], (n <= 16) ? 1'b1 : 1'b0);
    end

    drive(1, 0, 15, 0);
    chk("card15_digit0", bus.hex_out[6:0], 7'b1111111);
    chk("card15_blink0", bus.blinking[0], 1'b0);
    drive(1, 7, 5, 0);
    chk("slot7_hex", bus.hex_out,
        {7'b1111111, 7'b1111111, 7'b1111111, 7'b0001001, 7'b1111111, 7'b1111111});
    chk("slot7_blink", bus.blinking, 6'b000000);

    drive(1, 0, 9, 0);
    drive(1, 1, 8, 0);
    drive(1, 2, 12, 0);
    chk("score_blink", bus.blinking, 6'b000111);
`ifdef SCORE_DIGIT_EN
    chk("score_value7", bus.score_hex, 7'b1111000);
`endif

    repeat (5) drive(0, 0, 0, 0);
    drive(1, 1, 1, 0);
    chk("reload_digit1", bus.hex_out[13:7], 7'b0001000);
    chk("reload_blink1", bus.blinking[1], 1'b1);

    drive(1, 3, 5, 1);
    check_reset_outputs("clear_load");

    repeat (2000)
      drive($urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
            int'($urandom_range(0, 15)), $urandom_range(0, 63) == 0);

    for (int i = 0; i < NS; i++) drive(1, i, i + 1, 0);
    drive(0, 0, 0, 0);
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (6) drive(0, 0, 0, 0);
    drive(1, 4, 6, 0);
    repeat (10) drive(0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
